// File: rtl/shift595_controller.sv
// Serialises bytes MSB-first into a 74xx595, pulses RCLK to latch them, and issues
// shift-register clears. Every pin the 595 sees is driven straight from a flop.
module shift595_controller #(
  parameter int unsigned DIV = 2
) (
  input  logic       clock_50,
  input  logic       reset,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic       clr_req,
  input  logic       out_enable,
  output logic       done,
  output logic [7:0] latched_word,
  output logic       SER,
  output logic       SRCLK,
  output logic       RCLK,
  output logic       SRCLR_N,
  output logic       OE_N
);

  localparam int unsigned    PW      = $clog2(DIV + 1);
  localparam logic [PW-1:0]  PH_LOAD = PW'(DIV - 1);
  localparam logic [PW-1:0]  PH_ONE  = PW'(1);

  typedef enum logic [2:0] {IDLE, CLR, SH_LO, SH_HI, LAT_HI, LAT_LO} state_t;

  state_t        r_state;
  logic [PW-1:0] r_phase;
  logic [2:0]    r_bit;
  logic [7:0]    r_data;
  logic [7:0]    r_latched;
  logic          r_done;
  logic          r_in_ready;
  logic          r_ser;
  logic          r_srclk;
  logic          r_rclk;
  logic          r_srclr_n;
  logic          r_oe_n;

  state_t        w_state_next;
  logic [PW-1:0] w_phase_next;
  logic [2:0]    w_bit_next;
  logic [7:0]    w_data_next;
  logic [7:0]    w_latched_next;
  logic          w_done_next;
  logic          w_in_ready_next;
  logic          w_ser_next;
  logic          w_srclk_next;
  logic          w_rclk_next;
  logic          w_srclr_n_next;
  logic          w_phase_done;
  logic [PW-1:0] w_phase_dec;

  assign w_phase_done = (r_phase == '0);
  assign w_phase_dec  = r_phase - PH_ONE;

  always_comb begin
    w_state_next   = r_state;
    w_phase_next   = r_phase;
    w_bit_next     = r_bit;
    w_data_next    = r_data;
    w_latched_next = r_latched;
    w_done_next    = 1'b0;
    case (r_state)
      IDLE: begin
        if (clr_req) begin
          w_state_next = CLR;
          w_phase_next = PH_LOAD;
        end else if (in_valid) begin
          w_state_next = SH_LO;
          w_phase_next = PH_LOAD;
          w_data_next  = in_data;
          w_bit_next   = 3'd7;
        end
      end
      CLR: begin
        if (w_phase_done) begin
          w_state_next = IDLE;
          w_done_next  = 1'b1;
        end else begin
          w_phase_next = w_phase_dec;
        end
      end
      SH_LO: begin
        if (w_phase_done) begin
          w_state_next = SH_HI;
          w_phase_next = PH_LOAD;
        end else begin
          w_phase_next = w_phase_dec;
        end
      end
      SH_HI: begin
        if (w_phase_done) begin
          w_phase_next = PH_LOAD;
          if (r_bit != 3'd0) begin
            w_bit_next   = r_bit - 3'd1;
            w_state_next = SH_LO;
          end else begin
            w_state_next = LAT_HI;
          end
        end else begin
          w_phase_next = w_phase_dec;
        end
      end
      LAT_HI: begin
        // LAT_LO spans three half-phases so a whole word occupies 20 of them.
        if (w_phase_done) begin
          w_state_next = LAT_LO;
          w_phase_next = PH_LOAD;
          w_bit_next   = 3'd2;
        end else begin
          w_phase_next = w_phase_dec;
        end
      end
      LAT_LO: begin
        if (w_phase_done) begin
          if (r_bit != 3'd0) begin
            w_bit_next   = r_bit - 3'd1;
            w_phase_next = PH_LOAD;
          end else begin
            w_state_next   = IDLE;
            w_done_next    = 1'b1;
            w_latched_next = r_data;
          end
        end else begin
          w_phase_next = w_phase_dec;
        end
      end
      default: begin
        w_state_next = IDLE;
        w_phase_next = '0;
        w_bit_next   = 3'd0;
      end
    endcase

    // Pin values are decoded from the next state so the flops line up with it.
    w_in_ready_next = (w_state_next == IDLE);
    w_ser_next      = ((w_state_next == SH_LO) || (w_state_next == SH_HI)) ?
                      w_data_next[w_bit_next] : 1'b0;
    w_srclk_next    = (w_state_next == SH_HI);
    w_rclk_next     = (w_state_next == LAT_HI);
    w_srclr_n_next  = (w_state_next != CLR);
  end

  always_ff @(posedge clock_50 or posedge reset) begin
    if (reset) begin
      r_state    <= IDLE;
      r_phase    <= '0;
      r_bit      <= 3'd0;
      r_data     <= 8'h00;
      r_latched  <= 8'h00;
      r_done     <= 1'b0;
      r_in_ready <= 1'b1;
      r_ser      <= 1'b0;
      r_srclk    <= 1'b0;
      r_rclk     <= 1'b0;
      r_srclr_n  <= 1'b1;
      r_oe_n     <= 1'b1;
    end else begin
      r_state    <= w_state_next;
      r_phase    <= w_phase_next;
      r_bit      <= w_bit_next;
      r_data     <= w_data_next;
      r_latched  <= w_latched_next;
      r_done     <= w_done_next;
      r_in_ready <= w_in_ready_next;
      r_ser      <= w_ser_next;
      r_srclk    <= w_srclk_next;
      r_rclk     <= w_rclk_next;
      r_srclr_n  <= w_srclr_n_next;
      r_oe_n     <= ~out_enable;
    end
  end

  assign in_ready     = r_in_ready;
  assign done         = r_done;
  assign latched_word = r_latched;
  assign SER          = r_ser;
  assign SRCLK        = r_srclk;
  assign RCLK         = r_rclk;
  assign SRCLR_N      = r_srclr_n;
  assign OE_N         = r_oe_n;

endmodule
